sound_player: RTL and testbench

- Sequencer placed upstream of the per-effect sample ROMs (ufo, shot, explosion) in the audio path.
- On a trigger it sweeps the ROM address from 0 to depth-1, once per sample tick, and loops the sweep `repeats` times.
- It captures the returned 16-bit samples and presents them to the audio mixer/codec stage.

---
 rtl/sound_player.sv | 239 +++++++++++++++++++++++
 tb/tb_sound_player.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_player.sv
// sound_player: sweeps a sample ROM from address 0 to depth-1 once per
// sample tick, loops the sweep `repeats` times, and hands each captured
// 16-bit sample to the mixer with a one-cycle valid strobe.
// After every address change the ROM is given ROM_LAT clocks to settle.
// Service happens on the following edge, so the data is stable when it is captured.
module sound_player #(
  parameter int ROM_LAT  = 2,
  parameter int SETTLE_W = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        stop,
  input  logic        sample_tick,
  input  logic [17:0] depth,
  input  logic [31:0] repeats,
  input  logic [15:0] rom_dout,
  output logic [31:0] address,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    PLAY     = 2'd2,
    FINISH   = 2'd3
  } state_t;

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(ROM_LAT);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(32'd1);
  localparam logic [SETTLE_W-1:0] SETTLE_ZERO = SETTLE_W'(32'd0);

  state_t state;
  state_t state_next;

  // latched play parameters and sweep position
  logic [17:0]         dep_r;
  logic [17:0]         dep_next;
  logic [31:0]         rep_r;
  logic [31:0]         rep_next;
  logic [17:0]         idx;
  logic [17:0]         idx_next;
  logic [31:0]         pass;
  logic [31:0]         pass_next;
  logic [SETTLE_W-1:0] settle;
  logic [SETTLE_W-1:0] settle_next;
  logic                pending;
  logic                pending_next;

  // next values of the registered outputs
  logic [31:0] address_next;
  logic [15:0] sample_out_next;
  logic        sample_valid_next;
  logic        busy_next;
  logic        done_next;

  // decode helpers
  logic        service;
  logic        last_idx;
  logic        last_pass;
  logic        zero_len;
  logic        finishing;
  logic [17:0] idx_adv;
  logic [31:0] pass_inc;

  assign zero_len  = (depth == 18'd0) || (repeats == 32'd0);
  assign service   = (state == PLAY) && (settle == SETTLE_ZERO) && (sample_tick || pending);
  assign last_idx  = (idx == (dep_r - 18'd1));
  assign pass_inc  = pass + 32'd1;
  assign last_pass = (pass_inc == rep_r);
  assign idx_adv   = last_idx ? 18'd0 : (idx + 18'd1);
  assign finishing = service && last_idx && last_pass;

  // state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic: stop beats start, start restarts from any state
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = zero_len ? FINISH : PREFETCH;
    end else begin
      case (state)
        IDLE: begin
          state_next = IDLE;
        end
        PREFETCH: begin
          if (settle <= SETTLE_ONE) begin
            state_next = PLAY;
          end else begin
            state_next = PREFETCH;
          end
        end
        PLAY: begin
          if (finishing) begin
            state_next = FINISH;
          end else begin
            state_next = PLAY;
          end
        end
        FINISH: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // datapath and output next values
  always_comb begin
    dep_next          = dep_r;
    rep_next          = rep_r;
    idx_next          = idx;
    pass_next         = pass;
    settle_next       = settle;
    pending_next      = pending;
    address_next      = address;
    sample_out_next   = sample_out;
    sample_valid_next = 1'b0;
    done_next         = 1'b0;
    busy_next         = (state_next == PREFETCH) || (state_next == PLAY);
    if (stop) begin
      idx_next        = 18'd0;
      pass_next       = 32'd0;
      settle_next     = SETTLE_ZERO;
      pending_next    = 1'b0;
      address_next    = 32'd0;
      sample_out_next = 16'd0;
    end else if (start) begin
      dep_next        = depth;
      rep_next        = repeats;
      idx_next        = 18'd0;
      pass_next       = 32'd0;
      pending_next    = 1'b0;
      address_next    = 32'd0;
      sample_out_next = 16'd0;
      settle_next     = zero_len ? SETTLE_ZERO : SETTLE_LOAD;
    end else begin
      case (state)
        IDLE: begin
          sample_out_next = 16'd0;
        end
        PREFETCH: begin
          if (settle != SETTLE_ZERO) begin
            settle_next = settle - SETTLE_ONE;
          end else begin
            settle_next = SETTLE_ZERO;
          end
          if (sample_tick) begin
            pending_next = 1'b1;
          end else begin
            pending_next = pending;
          end
        end
        PLAY: begin
          if (service) begin
            sample_out_next   = rom_dout;
            sample_valid_next = 1'b1;
            pending_next      = 1'b0;
            idx_next          = idx_adv;
            settle_next       = SETTLE_LOAD;
            if (last_idx) begin
              pass_next = pass_inc;
            end else begin
              pass_next = pass;
            end
            // on the final sample the address is left where it was
            if (!finishing) begin
              address_next = {14'b0, idx_adv};
            end else begin
              address_next = address;
            end
          end else begin
            if (settle != SETTLE_ZERO) begin
              settle_next = settle - SETTLE_ONE;
            end else begin
              settle_next = SETTLE_ZERO;
            end
            if (sample_tick) begin
              pending_next = 1'b1;
            end else begin
              pending_next = pending;
            end
          end
        end
        FINISH: begin
          done_next       = 1'b1;
          sample_out_next = 16'd0;
        end
        default: begin
          sample_out_next = 16'd0;
        end
      endcase
    end
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dep_r        <= 18'd0;
      rep_r        <= 32'd0;
      idx          <= 18'd0;
      pass         <= 32'd0;
      settle       <= SETTLE_ZERO;
      pending      <= 1'b0;
      address      <= 32'd0;
      sample_out   <= 16'd0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      dep_r        <= dep_next;
      rep_r        <= rep_next;
      idx          <= idx_next;
      pass         <= pass_next;
      settle       <= settle_next;
      pending      <= pending_next;
      address      <= address_next;
      sample_out   <= sample_out_next;
      sample_valid <= sample_valid_next;
      busy         <= busy_next;
      done         <= done_next;
    end
  end

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: a two-stage ROM model, a behavioural player model
// compared against the DUT every clock, and directed plus random scenarios.
module tb_sound_player;

  localparam int ROM_LAT = 2;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sample_tick = 1'b0;
  logic [17:0] depth = 18'd0;
  logic [31:0] repeats = 32'd0;
  logic [15:0] rom_dout;
  logic [31:0] address;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sound_player #(.ROM_LAT(ROM_LAT), .SETTLE_W(3)) dut (
    .clk(clk), .resetN(resetN), .start(start), .stop(stop),
    .sample_tick(sample_tick), .depth(depth), .repeats(repeats),
    .rom_dout(rom_dout), .address(address), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .done(done)
  );

  function automatic logic [15:0] rom_f(input logic [31:0] a);
    return 16'h1000 + a[15:0];
  endfunction

  // ROM: data for a new address is valid ROM_LAT clocks after it changes
  logic [15:0] rom_p0 = 16'd0;
  logic [15:0] rom_p1 = 16'd0;
  always @(posedge clk) begin
    rom_p0 <= rom_f(address);
    rom_p1 <= rom_p0;
  end
  assign rom_dout = rom_p1;

  // ---------------- behavioural model ----------------
  int          m_mode = 0;          // 0 idle, 1 playing, 2 finishing
  longint      cyc = 0;
  longint      ready_at = 0;        // first edge at which a sample may be taken
  bit          m_pend = 1'b0;
  longint      m_dep = 0;
  longint      m_rep = 0;
  longint      m_idx = 0;
  longint      m_pass = 0;
  logic [31:0] e_addr = 32'd0;
  logic [15:0] e_sout = 16'd0;
  logic        e_valid = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;

  task automatic model_step();
    cyc++;
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (!resetN || stop) begin
      m_mode = 0; m_pend = 1'b0;
      e_addr = 32'd0; e_sout = 16'd0; e_busy = 1'b0;
    end else if (start) begin
      m_dep = depth; m_rep = repeats; m_idx = 0; m_pass = 0; m_pend = 1'b0;
      e_addr = 32'd0; e_sout = 16'd0;
      if (m_dep == 0 || m_rep == 0) begin
        m_mode = 2; e_busy = 1'b0;
      end else begin
        m_mode = 1; e_busy = 1'b1; ready_at = cyc + ROM_LAT + 1;
      end
    end else if (m_mode == 2) begin
      e_done = 1'b1; e_sout = 16'd0; m_mode = 0;
    end else if (m_mode == 0) begin
      e_sout = 16'd0;
    end else begin
      if (cyc >= ready_at && (sample_tick || m_pend)) begin
        e_sout = rom_f(32'(m_idx)); e_valid = 1'b1; m_pend = 1'b0;
        m_idx++;
        if (m_idx == m_dep) begin m_idx = 0; m_pass++; end
        if (m_pass == m_rep) begin
          m_mode = 2; e_busy = 1'b0;
        end else begin
          e_addr = 32'(m_idx); ready_at = cyc + ROM_LAT + 1;
        end
      end else if (sample_tick) begin
        m_pend = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare and observation ----------------
  longint      tcyc = 0;
  int          valid_cnt = 0;
  int          done_cnt = 0;
  longint      last_valid_cyc = 0;
  longint      first_valid_cyc = -1;
  longint      done_cyc = 0;
  bit          busy_seen = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [15:0] got_q[$];
  logic [31:0] addr_q[$];

  initial forever begin
    @(posedge clk);
    #1;
    tcyc++;
    chk("address", address, e_addr);
    chk("sample_out", 32'(sample_out), 32'(e_sout));
    chk("sample_valid", 32'(sample_valid), 32'(e_valid));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (sample_valid) begin
      got_q.push_back(sample_out);
      addr_q.push_back(prev_addr);
      valid_cnt++;
      last_valid_cyc = tcyc;
      if (first_valid_cyc < 0) first_valid_cyc = tcyc;
    end
    if (done) begin done_cnt++; done_cyc = tcyc; end
    if (busy) busy_seen = 1'b1;
    prev_addr = address;
  end

  // ---------------- stimulus helpers ----------------
  longint start_cyc = 0;

  task automatic pulse_start(input logic [17:0] d, input logic [31:0] r, input bit early);
    @(negedge clk);
    depth = d; repeats = r; start = 1'b1; sample_tick = 1'b0;
    @(negedge clk);
    start = 1'b0; sample_tick = early;
    start_cyc = tcyc;
    first_valid_cyc = -1;
  endtask

  task automatic pulse_stop();
    @(negedge clk); stop = 1'b1; sample_tick = 1'b0;
    @(negedge clk); stop = 1'b0;
  endtask

  // ticks with spacing lo+1..hi+1 until done, target samples, or budget
  task automatic play(input int lo, input int hi, input int first, input int target,
                      input int budget, output bit ok);
    int cnt; int d0; int v0;
    cnt = first; d0 = done_cnt; v0 = valid_cnt; ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done_cnt != d0 || (valid_cnt - v0) >= target) begin ok = 1'b1; break; end
      sample_tick = (cnt == 0);
      if (cnt == 0) cnt = int'($urandom_range(hi, lo)); else cnt--;
    end
    sample_tick = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bit ok; int v0; int d0;
    logic [15:0] exp_basic [8];
    logic [31:0] exp_addr [8];
    exp_basic = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1000, 16'h1001, 16'h1002, 16'h1003};
    exp_addr  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_address", address, 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_busy_done_valid", {29'd0, busy, done, sample_valid}, 32'd0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // basic play: depth 4, two passes, tick every 10 clk
    got_q.delete(); addr_q.delete(); d0 = done_cnt;
    pulse_start(18'd4, 32'd2, 1'b0);
    play(9, 9, 0, 1000, 400, ok);
    chk("basic_timeout", 32'(ok), 32'd1);
    chk("basic_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      chk("basic_value", 32'(got_q[i]), 32'(exp_basic[i]));
      chk("basic_addr", addr_q[i], exp_addr[i]);
    end
    chk("basic_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("basic_done_lag", 32'(done_cyc - last_valid_cyc), 32'd1);
    @(negedge clk);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_idle_sout", 32'(sample_out), 32'd0);

    // zero guards
    for (int z = 0; z < 2; z++) begin
      busy_seen = 1'b0; v0 = valid_cnt; d0 = done_cnt;
      if (z == 0) pulse_start(18'd0, 32'd3, 1'b0);
      else        pulse_start(18'd5, 32'd0, 1'b0);
      @(negedge clk);
      chk("zero_done_fast", 32'(done_cnt - d0), 32'd1);
      play(3, 3, 0, 1000, 12, ok);
      chk("zero_no_valid", 32'(valid_cnt - v0), 32'd0);
      chk("zero_no_busy", 32'(busy_seen), 32'd0);
      chk("zero_one_done", 32'(done_cnt - d0), 32'd1);
    end

    // early tick one clock after start
    got_q.delete(); d0 = done_cnt;
    pulse_start(18'd3, 32'd1, 1'b1);
    play(5, 5, 6, 1000, 200, ok);
    chk("early_timeout", 32'(ok), 32'd1);
    chk("early_latency", 32'(first_valid_cyc - start_cyc), 32'(ROM_LAT + 1));
    chk("early_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("early_v0", 32'(got_q[0]), 32'h1000);
      chk("early_v2", 32'(got_q[2]), 32'h1002);
    end
    chk("early_done", 32'(done_cnt - d0), 32'd1);

    // retrigger after the fifth sample
    got_q.delete(); d0 = done_cnt;
    pulse_start(18'd8, 32'd1, 1'b0);
    play(4, 4, 0, 5, 200, ok);
    chk("retrig_first_part", 32'(got_q.size()), 32'd5);
    pulse_start(18'd8, 32'd1, 1'b0);
    chk("retrig_addr0", address, 32'd0);
    chk("retrig_busy", 32'(busy), 32'd1);
    v0 = valid_cnt;
    play(4, 4, 0, 1000, 300, ok);
    chk("retrig_timeout", 32'(ok), 32'd1);
    chk("retrig_count", 32'(valid_cnt - v0), 32'd8);
    if (got_q.size() == 13) begin
      chk("retrig_v_first", 32'(got_q[5]), 32'h1000);
      chk("retrig_v_last", 32'(got_q[12]), 32'h1007);
    end
    chk("retrig_one_done", 32'(done_cnt - d0), 32'd1);

    // abort on the third service cycle, then start+stop together
    d0 = done_cnt;
    pulse_start(18'd6, 32'd1, 1'b0);
    v0 = valid_cnt;
    play(4, 4, 0, 2, 200, ok);
    repeat (4) @(negedge clk);
    sample_tick = 1'b1; stop = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0; stop = 1'b0;
    chk("abort_sout", 32'(sample_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", address, 32'd0);
    chk("abort_valid_cnt", 32'(valid_cnt - v0), 32'd2);
    @(negedge clk);
    depth = 18'd4; repeats = 32'd1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    busy_seen = 1'b0;
    play(3, 3, 0, 1000, 20, ok);
    chk("startstop_busy", 32'(busy_seen), 32'd0);
    chk("startstop_valid", 32'(valid_cnt - v0), 32'd2);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // async reset between ticks
    d0 = done_cnt;
    pulse_start(18'd5, 32'd2, 1'b0);
    play(4, 4, 0, 3, 200, ok);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    chk("areset_address", address, 32'd0);
    chk("areset_outs", {15'd0, sample_out, busy, done, sample_valid}, 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    v0 = valid_cnt; busy_seen = 1'b0;
    play(3, 3, 0, 1000, 20, ok);
    chk("areset_quiet_valid", 32'(valid_cnt - v0), 32'd0);
    chk("areset_quiet_busy", 32'(busy_seen), 32'd0);
    chk("areset_no_done", 32'(done_cnt - d0), 32'd0);

    // very long loop count keeps playing
    d0 = done_cnt;
    pulse_start(18'd2, 32'hFFFF_FFFF, 1'b0);
    play(3, 3, 0, 1000, 60, ok);
    chk("long_still_busy", 32'(busy), 32'd1);
    chk("long_no_done", 32'(done_cnt - d0), 32'd0);
    pulse_stop();

    // randomized plays checked by the model
    for (int it = 0; it < 40; it++) begin
      logic [17:0] d; logic [31:0] r;
      d = ($urandom_range(9, 0) == 0) ? 18'd0 : 18'($urandom_range(5, 1));
      r = ($urandom_range(9, 0) == 0) ? 32'd0 : 32'($urandom_range(3, 1));
      pulse_start(d, r, 1'($urandom_range(1, 0)));
      if (it % 6 == 5) begin
        play(3, 11, int'($urandom_range(4, 1)), int'($urandom_range(4, 1)), 300, ok);
        pulse_stop();
      end else if (it % 6 == 2) begin
        play(3, 11, int'($urandom_range(4, 1)), 2, 300, ok);
        pulse_start(d, r, 1'b0);
        play(3, 11, int'($urandom_range(4, 0)), 1000, 600, ok);
      end else begin
        play(3, 11, int'($urandom_range(4, 0)), 1000, 600, ok);
      end
      chk("rand_timeout", 32'(ok), 32'd1);
      repeat ($urandom_range(3, 0)) begin
        @(negedge clk);
        sample_tick = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
      sample_tick = 1'b0;
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
